// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Data-memory responder for the Memory stage of the pipeline. It accepts one
//   load/store at a time over a valid/ready handshake and returns the response
//   exactly LATENCY cycles after the accept cycle. While the access is in flight,
//   Stall holds the Memory stage. Storage is an array of 2**ADDR_BITS 32-bit words.
//
//   Optional feature macro: DMEM_BYTE_LANES_EN
//     defined   : byte/halfword accesses via i_Size, sign/zero extension via
//                 i_SignedLoad, and little-endian lane select by address bits [1:0]
//     undefined : every access is a full word, i_Size/i_SignedLoad are ignored,
//                 and any address with bits [1:0] != 0 faults
//
// Parameters
//   LATENCY    cycles from the accept cycle to the RespValid cycle (legal 1..15)
//   ADDR_BITS  word-address width
//
// Ports
//   i_Clk         clock, rising edge
//   i_Rst         synchronous active-high reset
//   i_ReqValid    request present
//   i_ReqWrite    1 = store, 0 = load
//   i_Addr        byte address
//   i_WriteData   store data (sub-word data in the low bits)
//   i_Size        00 byte, 01 half, 10 word, 11 illegal
//   i_SignedLoad  sign-extend sub-word loads
//   o_ReqReady    request can be accepted this cycle
//   o_RespValid   one-cycle response pulse
//   o_ReadData    load result, nonzero only while o_RespValid is high
//   o_Error       qualifies o_RespValid: the request faulted
//   o_Stall       combinational: hold the Memory stage
`default_nettype none

module data_memory_responder #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_ReqValid,
  input  logic        i_ReqWrite,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WriteData,
  input  logic [1:0]  i_Size,
  input  logic        i_SignedLoad,
  output logic        o_ReqReady,
  output logic        o_RespValid,
  output logic [31:0] o_ReadData,
  output logic        o_Error,
  output logic        o_Stall
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_write;

  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_error;
  logic [31:0]      r_rdata;

  logic [31:0]      r_mem [DEPTH];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_commit;
  logic [31:0]      w_op_addr;
  logic [31:0]      w_op_wdata;
  logic             w_op_write;
  logic [ADDR_BITS-1:0] w_idx;
  logic             w_oor;
  logic             w_misalign;
  logic             w_bad_size;
  logic             w_err;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_rword;
  logic [31:0]      w_rdata;

  assign w_accept     = (r_state == S_IDLE) && i_ReqValid;
  assign w_enter_resp = (w_state_nxt == S_RESP);

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; BUSY exits when the countdown reaches one
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_ReqValid) begin
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_count == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latency countdown, loaded with LATENCY-1 on accept
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= CNT_W'(LATENCY - 1);
    end else if (r_state == S_BUSY) begin
      r_count <= (r_count == 4'd1) ? '0 : r_count - 4'd1;
    end
  end

  // Request capture on accept
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= i_Addr;
      r_wdata <= i_WriteData;
      r_write <= i_ReqWrite;
    end
  end

  // With LATENCY==1 the commit edge is the accept edge, so operands come
  // straight from the inputs in that case rather than from the capture regs.
  assign w_op_addr  = w_accept ? i_Addr      : r_addr;
  assign w_op_wdata = w_accept ? i_WriteData : r_wdata;
  assign w_op_write = w_accept ? i_ReqWrite  : r_write;

  assign w_idx   = w_op_addr[ADDR_BITS+1:2];
  assign w_oor   = (w_op_addr >> (ADDR_BITS + 2)) != 32'd0;
  assign w_rword = r_mem[w_idx];

`ifdef DMEM_BYTE_LANES_EN
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  w_op_size;
  logic        w_op_signed;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;

  // Sub-word attributes captured alongside the rest of the request
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_size   <= 2'b10;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_size   <= i_Size;
      r_signed <= i_SignedLoad;
    end
  end

  assign w_op_size   = w_accept ? i_Size       : r_size;
  assign w_op_signed = w_accept ? i_SignedLoad : r_signed;

  // Fault decode, byte enables and replicated store lanes
  always_comb begin
    w_bad_size = (w_op_size == SZ_ILL);
    w_misalign = 1'b0;
    w_be       = 4'hF;
    w_wlanes   = w_op_wdata;
    case (w_op_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << w_op_addr[1:0];
        w_wlanes = {4{w_op_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_misalign = w_op_addr[0];
        w_be       = w_op_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes   = {2{w_op_wdata[15:0]}};
      end
      default: begin
        w_misalign = (w_op_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Little-endian lane select followed by sign/zero extension
  always_comb begin
    w_rbyte = w_rword[{w_op_addr[1:0], 3'b000} +: 8];
    w_rhalf = w_op_addr[1] ? w_rword[31:16] : w_rword[15:0];
    case (w_op_size)
      SZ_BYTE: w_rdata = w_op_signed ? {{24{w_rbyte[7]}}, w_rbyte} : {24'd0, w_rbyte};
      SZ_HALF: w_rdata = w_op_signed ? {{16{w_rhalf[15]}}, w_rhalf} : {16'd0, w_rhalf};
      default: w_rdata = w_rword;
    endcase
  end
`else
  logic w_unused_ok;

  // Word-only build: size/sign inputs have no effect
  assign w_unused_ok = ^{i_Size, i_SignedLoad};
  assign w_bad_size  = 1'b0;
  assign w_misalign  = (w_op_addr[1:0] != 2'b00);
  assign w_be        = 4'hF;
  assign w_wlanes    = w_op_wdata;
  assign w_rdata     = w_rword;
`endif

  assign w_err    = w_oor || w_bad_size || w_misalign;
  // A reset on the would-be commit edge aborts the store
  assign w_commit = !i_Rst && w_enter_resp && w_op_write && !w_err;

  // Storage array; never cleared by reset
  always_ff @(posedge i_Clk) begin
    if (w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
        end
      end
    end
  end

  // Registered response outputs; data and error are loaded on the edge into RESP
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_error      <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= w_enter_resp;
      r_error      <= w_enter_resp && w_err;
      r_rdata      <= (w_enter_resp && !w_err && !w_op_write) ? w_rdata : 32'd0;
    end
  end

  assign o_ReqReady  = r_req_ready;
  assign o_RespValid = r_resp_valid;
  assign o_Error     = r_error;
  assign o_ReadData  = r_rdata;
  assign o_Stall     = ((r_state == S_IDLE) && i_ReqValid) || (r_state == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: three instances (LATENCY 2, 1, 15)
// share clock, reset and request payload; each has its own ReqValid.
module tb_data_memory_responder;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;
  localparam logic [1:0] SZX = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rv;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sgn;
  logic [2:0]  rdy;
  logic [2:0]  rvld;
  logic [2:0]  erv;
  logic [2:0]  stl;
  logic [2:0][31:0] rdat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.LATENCY(2), .ADDR_BITS(10)) u_dut_l2 (
    .i_Clk(clk), .i_Rst(rst), .i_ReqValid(rv[0]), .i_ReqWrite(wr), .i_Addr(addr),
    .i_WriteData(wdata), .i_Size(size), .i_SignedLoad(sgn), .o_ReqReady(rdy[0]),
    .o_RespValid(rvld[0]), .o_ReadData(rdat[0]), .o_Error(erv[0]), .o_Stall(stl[0])
  );

  data_memory_responder #(.LATENCY(1), .ADDR_BITS(10)) u_dut_l1 (
    .i_Clk(clk), .i_Rst(rst), .i_ReqValid(rv[1]), .i_ReqWrite(wr), .i_Addr(addr),
    .i_WriteData(wdata), .i_Size(size), .i_SignedLoad(sgn), .o_ReqReady(rdy[1]),
    .o_RespValid(rvld[1]), .o_ReadData(rdat[1]), .o_Error(erv[1]), .o_Stall(stl[1])
  );

  data_memory_responder #(.LATENCY(15), .ADDR_BITS(10)) u_dut_l15 (
    .i_Clk(clk), .i_Rst(rst), .i_ReqValid(rv[2]), .i_ReqWrite(wr), .i_Addr(addr),
    .i_WriteData(wdata), .i_Size(size), .i_SignedLoad(sgn), .o_ReqReady(rdy[2]),
    .o_RespValid(rvld[2]), .o_ReadData(rdat[2]), .o_Error(erv[2]), .o_Stall(stl[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on instance sel; lat counts rising edges from the accept edge
  // (accept edge = 1) to the first cycle with RespValid high.
  task automatic do_req(input int sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sg,
                        output int lat, output logic [31:0] rd, output logic er);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rdy[sel] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    wr = w; addr = a; wdata = d; size = sz; sgn = sg;
    rv[sel] = 1'b1;
    @(posedge clk);
    #1;
    rv[sel] = 1'b0;
    lat = 1;
    while (!rvld[sel] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rdat[sel];
    er = erv[sel];
  endtask

  task automatic xact(input string tag, input int sel, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz, input logic sg,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
    int          lat;
    logic [31:0] rd;
    logic        er;
    do_req(sel, w, a, d, sz, sg, lat, rd, er);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    if (!w) check({tag, "_data"}, rd, exp_rd);
  endtask

  initial begin
    rst = 1'b1; rv = '0; wr = 1'b0; addr = '0; wdata = '0; size = SZW; sgn = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, rdy[0]},  32'd1);
    check("rst_resp",  {31'd0, rvld[0]}, 32'd0);
    check("rst_err",   {31'd0, erv[0]},  32'd0);
    check("rst_data",  rdat[0],          32'd0);
    check("rst_stall", {31'd0, stl[0]},  32'd0);
    rv[0] = 1'b1;
    #1;
    check("rst_stall_follow", {31'd0, stl[0]}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_no_accept", {31'd0, rdy[0]}, 32'd1);
    rv[0] = 1'b0;
    rst = 1'b0;

    // Basic store/load, LATENCY=2
    xact("st_10", 0, 1'b1, 32'h10, 32'hDEADBEEF, SZW, 1'b0, 2, 32'd0, 1'b0);
    xact("ld_10", 0, 1'b0, 32'h10, 32'd0,        SZW, 1'b0, 2, 32'hDEADBEEF, 1'b0);

    // Held ReqValid: stall profile, bubble, re-accept
    @(negedge clk);
    while (!rdy[0]) @(negedge clk);
    wr = 1'b0; addr = 32'h10; size = SZW; sgn = 1'b0; rv[0] = 1'b1;
    #1;
    check("hold_c_stall", {31'd0, stl[0]}, 32'd1);
    @(posedge clk); #1;
    check("hold_c1_stall", {31'd0, stl[0]},  32'd1);
    check("hold_c1_resp",  {31'd0, rvld[0]}, 32'd0);
    @(posedge clk); #1;
    check("hold_c2_stall", {31'd0, stl[0]},  32'd0);
    check("hold_c2_resp",  {31'd0, rvld[0]}, 32'd1);
    check("hold_c2_ready", {31'd0, rdy[0]},  32'd0);
    check("hold_c2_data",  rdat[0],          32'hDEADBEEF);
    @(posedge clk); #1;
    check("hold_c3_ready", {31'd0, rdy[0]},  32'd1);
    check("hold_c3_stall", {31'd0, stl[0]},  32'd1);
    check("hold_c3_resp",  {31'd0, rvld[0]}, 32'd0);
    @(posedge clk); #1;
    check("hold_c4_ready", {31'd0, rdy[0]},  32'd0);
    check("hold_c4_stall", {31'd0, stl[0]},  32'd1);
    rv[0] = 1'b0;
    @(posedge clk); #1;
    check("hold_c5_resp",  {31'd0, rvld[0]}, 32'd1);
    check("hold_c5_data",  rdat[0],          32'hDEADBEEF);

    // Faults
    xact("ld_mis12", 0, 1'b0, 32'h12,   32'd0,        SZW, 1'b0, 2, 32'd0, 1'b1);
    xact("st_0",     0, 1'b1, 32'h0,    32'h01020304, SZW, 1'b0, 2, 32'd0, 1'b0);
    xact("st_oor",   0, 1'b1, 32'h1000, 32'h55555555, SZW, 1'b0, 2, 32'd0, 1'b1);
    xact("ld_oor",   0, 1'b0, 32'h1000, 32'd0,        SZW, 1'b0, 2, 32'd0, 1'b1);
    xact("ld_0",     0, 1'b0, 32'h0,    32'd0,        SZW, 1'b0, 2, 32'h01020304, 1'b0);

`ifdef DMEM_BYTE_LANES_EN
    // Sub-word lanes
    xact("st_20",    0, 1'b1, 32'h20, 32'h11223344, SZW, 1'b0, 2, 32'd0, 1'b0);
    xact("stb_21",   0, 1'b1, 32'h21, 32'h00000080, SZB, 1'b0, 2, 32'd0, 1'b0);
    xact("ld_20",    0, 1'b0, 32'h20, 32'd0,        SZW, 1'b0, 2, 32'h11228044, 1'b0);
    xact("lbs_21",   0, 1'b0, 32'h21, 32'd0,        SZB, 1'b1, 2, 32'hFFFFFF80, 1'b0);
    xact("lbu_21",   0, 1'b0, 32'h21, 32'd0,        SZB, 1'b0, 2, 32'h00000080, 1'b0);
    xact("lhs_22",   0, 1'b0, 32'h22, 32'd0,        SZH, 1'b1, 2, 32'h00001122, 1'b0);
    xact("sth_22",   0, 1'b1, 32'h22, 32'h0000BEEF, SZH, 1'b0, 2, 32'd0, 1'b0);
    xact("lhs_22b",  0, 1'b0, 32'h22, 32'd0,        SZH, 1'b1, 2, 32'hFFFFBEEF, 1'b0);
    xact("ld_20b",   0, 1'b0, 32'h20, 32'd0,        SZW, 1'b0, 2, 32'hBEEF8044, 1'b0);
    xact("lh_mis21", 0, 1'b0, 32'h21, 32'd0,        SZH, 1'b0, 2, 32'd0, 1'b1);
    xact("st_ill",   0, 1'b1, 32'h20, 32'hFFFFFFFF, SZX, 1'b0, 2, 32'd0, 1'b1);
    xact("ld_20c",   0, 1'b0, 32'h20, 32'd0,        SZW, 1'b0, 2, 32'hBEEF8044, 1'b0);
`else
    // Word-only build: size ignored, any low address bit faults
    xact("st_20",    0, 1'b1, 32'h20, 32'h11223344, SZB, 1'b0, 2, 32'd0, 1'b0);
    xact("ld_20",    0, 1'b0, 32'h20, 32'd0,        SZB, 1'b1, 2, 32'h11223344, 1'b0);
    xact("stb_21",   0, 1'b1, 32'h21, 32'h00000080, SZB, 1'b0, 2, 32'd0, 1'b1);
    xact("ld_20b",   0, 1'b0, 32'h20, 32'd0,        SZW, 1'b0, 2, 32'h11223344, 1'b0);
    xact("lh_22",    0, 1'b0, 32'h22, 32'd0,        SZH, 1'b0, 2, 32'd0, 1'b1);
`endif

    // Reset during BUSY aborts the store
    xact("st_30", 0, 1'b1, 32'h30, 32'hA5A5A5A5, SZW, 1'b0, 2, 32'd0, 1'b0);
    @(negedge clk);
    while (!rdy[0]) @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; size = SZW; sgn = 1'b0; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    check("abort_busy_stall", {31'd0, stl[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_resp",  {31'd0, rvld[0]}, 32'd0);
    check("abort_err",   {31'd0, erv[0]},  32'd0);
    check("abort_data",  rdat[0],          32'd0);
    check("abort_ready", {31'd0, rdy[0]},  32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_resp2", {31'd0, rvld[0]}, 32'd0);
    xact("ld_30", 0, 1'b0, 32'h30, 32'd0, SZW, 1'b0, 2, 32'hA5A5A5A5, 1'b0);

    // Latency extremes
    xact("l1_st",  1, 1'b1, 32'h40, 32'h12345678, SZW, 1'b0, 1,  32'd0, 1'b0);
    xact("l1_ld",  1, 1'b0, 32'h40, 32'd0,        SZW, 1'b0, 1,  32'h12345678, 1'b0);
    xact("l1_mis", 1, 1'b0, 32'h43, 32'd0,        SZW, 1'b0, 1,  32'd0, 1'b1);
    xact("l15_st", 2, 1'b1, 32'h44, 32'h0BADF00D, SZW, 1'b0, 15, 32'd0, 1'b0);
    xact("l15_ld", 2, 1'b0, 32'h44, 32'd0,        SZW, 1'b0, 15, 32'h0BADF00D, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
